// File: rtl/ofdm_demap_pkg.sv
// Shared constants, FSM state type and bit-assembly helpers for the QAM demapper.
package ofdm_demap_pkg;

    localparam logic [2:0] MODE_BPSK  = 3'd0;
    localparam logic [2:0] MODE_QPSK  = 3'd1;
    localparam logic [2:0] MODE_16QAM = 3'd2;
    localparam logic [2:0] MODE_64QAM = 3'd3;

    // Accumulator holds up to 7 leftover bits plus one 6-bit sample.
    localparam int ACC_W = 14;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_e;

    // Decided bits contributed by one sample; reserved modes contribute none.
    function automatic logic [2:0] bits_per_mode(input logic [2:0] mode);
        case (mode)
            MODE_BPSK:  bits_per_mode = 3'd1;
            MODE_QPSK:  bits_per_mode = 3'd2;
            MODE_16QAM: bits_per_mode = 3'd4;
            MODE_64QAM: bits_per_mode = 3'd6;
            default:    bits_per_mode = 3'd0;
        endcase
    endfunction

    // Orders the axis decisions {s_i, m1_i, m2_i, s_q, m1_q, m2_q} into a
    // left-justified 6-bit field: I bits first, sign first within each axis.
    // The 16-QAM inner decision |x| < 2L equals m1 & ~m2 of the 64-QAM slicer.
    function automatic logic [5:0] pack_decisions(input logic [2:0] mode,
                                                  input logic [5:0] dec);
        case (mode)
            MODE_BPSK:  pack_decisions = {dec[5], 5'b0};
            MODE_QPSK:  pack_decisions = {dec[5], dec[2], 4'b0};
            MODE_16QAM: pack_decisions = {dec[5], dec[4] & ~dec[3],
                                          dec[2], dec[1] & ~dec[0], 2'b0};
            MODE_64QAM: pack_decisions = dec;
            default:    pack_decisions = 6'b0;
        endcase
    endfunction

endpackage

// File: rtl/ofdm_axis_slicer.sv
// Per-axis hard slicer: sign plus the two 64-QAM magnitude decisions.
module ofdm_axis_slicer #(
    parameter int DATA_SIZE = 16,
    parameter int LEVEL     = 1024
) (
    input  logic signed [DATA_SIZE-1:0] i_data,
    output logic                        o_sign,
    output logic                        o_m1,
    output logic                        o_m2
);

    if (6 * LEVEL >= 2 ** (DATA_SIZE - 1)) begin : g_level_check
        $error("ofdm_axis_slicer: 6*LEVEL does not fit in DATA_SIZE-1 magnitude bits");
    end

    localparam logic [DATA_SIZE-2:0] THR_2L = (DATA_SIZE - 1)'(2 * LEVEL);
    localparam logic [DATA_SIZE-2:0] THR_4L = (DATA_SIZE - 1)'(4 * LEVEL);
    localparam logic [DATA_SIZE-2:0] THR_6L = (DATA_SIZE - 1)'(6 * LEVEL);

    logic [DATA_SIZE-2:0] mag;

    // Saturating magnitude: the most negative code maps to the largest positive one.
    always_comb begin
        // NOTE: every branch assigns mag, so no latch is inferred.
        if (!i_data[DATA_SIZE-1]) begin
            mag = i_data[DATA_SIZE-2:0];
        end else if (i_data[DATA_SIZE-2:0] == '0) begin
            mag = '1;
        end else begin
            mag = (DATA_SIZE - 1)'(~i_data + 1'b1);
        end
    end

    // Exact threshold values fall into the outer region.
    assign o_sign = i_data[DATA_SIZE-1];
    assign o_m1   = (mag < THR_4L);
    assign o_m2   = (mag >= THR_2L) && (mag < THR_6L);

endmodule

// File: rtl/ofdm_qam_demap.sv
// Hard-decision QAM demapper and MSB-first byte packer with frame-last marking.
module ofdm_qam_demap
    import ofdm_demap_pkg::*;
#(
    parameter int DATA_SIZE = 16,
    parameter int LEVEL     = 1024
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_valid,
    input  logic [DATA_SIZE-1:0] in_data_i,
    input  logic [DATA_SIZE-1:0] in_data_q,
    input  logic                 i_last,
    input  logic [2:0]           i_mode,
    output logic [7:0]           o_data,
    output logic                 o_valid,
    output logic                 o_last,
    output logic                 o_busy,
    output logic                 o_mode_err
);

    logic sign_i, m1_i, m2_i, sign_q, m1_q, m2_q;

    ofdm_axis_slicer #(.DATA_SIZE(DATA_SIZE), .LEVEL(LEVEL)) u_slice_i (
        .i_data (in_data_i),
        .o_sign (sign_i),
        .o_m1   (m1_i),
        .o_m2   (m2_i)
    );

    ofdm_axis_slicer #(.DATA_SIZE(DATA_SIZE), .LEVEL(LEVEL)) u_slice_q (
        .i_data (in_data_q),
        .o_sign (sign_q),
        .o_m1   (m1_q),
        .o_m2   (m2_q)
    );

    // Stage 1 registers
    logic       s1_valid_q, s1_valid_d;
    logic       s1_last_q,  s1_last_d;
    logic [2:0] s1_mode_q,  s1_mode_d;
    logic [5:0] s1_dec_q,   s1_dec_d;

    // Stage 2 / frame state
    state_e             state_q,    state_d;
    logic [2:0]         mode_q,     mode_d;
    logic [ACC_W-1:0]   acc_q,      acc_d;
    logic [CNT_W-1:0]   cnt_q,      cnt_d;
    logic               mode_err_q, mode_err_d;
    logic [7:0]         data_q,     data_d;
    logic               valid_q,    valid_d;
    logic               last_q,     last_d;

    logic [2:0]         cur_mode;
    logic [5:0]         sbits;
    logic [ACC_W-1:0]   base_acc, sum_acc;
    logic [CNT_W-1:0]   base_cnt, sum_cnt;

    // Stage 1: capture the slicer decisions and the sample's framing.
    always_comb begin
        s1_valid_d = i_valid;
        s1_last_d  = i_valid & i_last;
        s1_mode_d  = i_mode;
        s1_dec_d   = {sign_i, m1_i, m2_i, sign_q, m1_q, m2_q};
    end

    // Stage 2: frame FSM, bit accumulation, byte extraction and flush.
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        mode_err_d = mode_err_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        last_d     = 1'b0;
        cur_mode   = mode_q;
        base_acc   = acc_q;
        base_cnt   = cnt_q;
        sbits      = '0;
        sum_acc    = '0;
        sum_cnt    = '0;

        if (state_q == FLUSH) begin
            // Residual is already left-justified with zeros below it.
            valid_d  = 1'b1;
            last_d   = 1'b1;
            data_d   = acc_q[ACC_W-1 -: 8];
            base_acc = '0;
            base_cnt = '0;
            acc_d    = '0;
            cnt_d    = '0;
            state_d  = IDLE;
        end

        if (s1_valid_q) begin
            if (state_q != RUN) begin
                cur_mode = s1_mode_q;
                mode_d   = s1_mode_q;
                if (s1_mode_q[2]) begin
                    mode_err_d = 1'b1;
                end
                state_d = RUN;
            end

            sbits   = pack_decisions(cur_mode, s1_dec_q);
            sum_acc = base_acc | ({sbits, 8'b0} >> base_cnt);
            sum_cnt = base_cnt + {1'b0, bits_per_mode(cur_mode)};
            acc_d   = sum_acc;
            cnt_d   = sum_cnt;

            // A flush cycle starts from an empty accumulator, so this never collides with it.
            if (sum_cnt >= 4'd8) begin
                valid_d = 1'b1;
                data_d  = sum_acc[ACC_W-1 -: 8];
                last_d  = s1_last_q && (sum_cnt == 4'd8);
                acc_d   = sum_acc << 8;
                cnt_d   = sum_cnt - 4'd8;
            end

            if (s1_last_q) begin
                state_d = (cnt_d != 4'd0) ? FLUSH : IDLE;
            end
        end
    end

    // Register both stages; reset discards any partially packed bits.
    always_ff @(posedge i_clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values.
        if (i_reset) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_mode_q  <= '0;
            s1_dec_q   <= '0;
            state_q    <= IDLE;
            mode_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            mode_err_q <= 1'b0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_mode_q  <= s1_mode_d;
            s1_dec_q   <= s1_dec_d;
            state_q    <= state_d;
            mode_q     <= mode_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            mode_err_q <= mode_err_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
        end
    end

    assign o_data     = data_q;
    assign o_valid    = valid_q;
    assign o_last     = last_q;
    assign o_busy     = (state_q != IDLE);
    assign o_mode_err = mode_err_q;

endmodule
